core_ctrl: RTL

CORE_CTRL -- requirements
Module: core_ctrl

---
 rtl/core_ctrl_pkg.sv | 32 +++
 rtl/core_ctrl_addr_gen.sv | 10 +
 rtl/core_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/core_ctrl_pkg.sv
// core_ctrl_pkg: FSM states, instruction bit map, idle instruction and default sizes for core_ctrl
package core_ctrl_pkg;
  localparam int ROW      = 8;
  localparam int COL      = 8;
  localparam int LEN_KIJ  = 9;
  localparam int LEN_NIJ  = 36;
  localparam int LEN_ONIJ = 16;
  localparam int IW       = 6;
  localparam int OW       = 4;
  localparam int KA       = 3;
  localparam int GAP_LEN  = 10;
  localparam int ACC_WIN  = 12;
  localparam logic [10:0] WBASE = 11'h400;
  localparam int B_ACC      = 33;
  localparam int B_CEN_P    = 32;
  localparam int B_WEN_P    = 31;
  localparam int B_A_P      = 20;
  localparam int B_CEN_X    = 19;
  localparam int B_WEN_X    = 18;
  localparam int B_A_X      = 7;
  localparam int B_OFIFO_RD = 6;
  localparam int B_IFIFO_WR = 5;
  localparam int B_IFIFO_RD = 4;
  localparam int B_L0_RD    = 3;
  localparam int B_L0_WR    = 2;
  localparam int B_EXEC     = 1;
  localparam int B_LOAD     = 0;
  localparam logic [33:0] IDLE_INST = 34'h1_800C_0000;
  typedef enum logic [3:0] {
    IDLE, L0W_W, KLOAD, GAP, L0W_X, EXEC, WAIT_OF, DRAIN, ACC, FIN
  } state_t;
endpackage

// File: rtl/core_ctrl_addr_gen.sv
// core_ctrl_addr_gen: psum memory address of kernel tap k for output pixel o
module core_ctrl_addr_gen
  import core_ctrl_pkg::*;
(
  input  logic [3:0]  k,
  input  logic [3:0]  o,
  output logic [10:0] addr
);
  assign addr = 11'(int'(k) * LEN_NIJ + (int'(o) / OW + int'(k) / KA) * IW + int'(o) % OW + int'(k) % KA);
endmodule

// File: rtl/core_ctrl.sv
// core_ctrl: convolution run sequencer for the systolic core; CORE_CTRL_PERF_EN adds perf counters
module core_ctrl
  import core_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ofifo_valid,
  output logic [33:0] inst,
  output logic        sfp_clr,
  output logic        out_valid,
  output logic [3:0]  out_idx,
  output logic        busy,
  output logic        done
`ifdef CORE_CTRL_PERF_EN
  ,
  output logic [31:0] perf_cycles,
  output logic [15:0] perf_stall
`endif
);
  state_t state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [3:0] kij_q, kij_d;
  logic [3:0] o_q, o_d;
  logic [33:0] inst_q, inst_d;
  logic sfp_clr_q, sfp_clr_d;
  logic out_valid_q, out_valid_d;
  logic [3:0] out_idx_q, out_idx_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic [3:0] acc_k;
  logic [10:0] acc_addr;

  assign acc_k = 4'(cnt_d - 6'd1);

  core_ctrl_addr_gen u_addr (
    .k    (acc_k),
    .o    (o_d),
    .addr (acc_addr)
  );

  // phase sequencing: cnt is the cycle index within the current phase
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 6'd1;
    kij_d = kij_q;
    o_d = o_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        kij_d = '0;
        o_d = '0;
        if (start) state_d = L0W_W;
      end
      L0W_W: if (cnt_q == 6'(COL)) begin
        state_d = KLOAD;
        cnt_d = '0;
      end
      KLOAD: if (cnt_q == 6'(COL - 1)) begin
        state_d = GAP;
        cnt_d = '0;
      end
      GAP: if (cnt_q == 6'(GAP_LEN - 1)) begin
        state_d = L0W_X;
        cnt_d = '0;
      end
      L0W_X: if (cnt_q == 6'(LEN_NIJ)) begin
        state_d = EXEC;
        cnt_d = '0;
      end
      EXEC: if (cnt_q == 6'(LEN_NIJ + ROW + COL - 1)) begin
        state_d = ofifo_valid ? DRAIN : WAIT_OF;
        cnt_d = '0;
      end
      WAIT_OF: begin
        cnt_d = '0;
        if (ofifo_valid) state_d = DRAIN;
      end
      DRAIN: if (cnt_q == 6'(LEN_NIJ)) begin
        cnt_d = '0;
        state_d = (kij_q == 4'(LEN_KIJ - 1)) ? ACC : L0W_W;
        kij_d = (kij_q == 4'(LEN_KIJ - 1)) ? kij_q : kij_q + 4'd1;
      end
      ACC: if (cnt_q == 6'(ACC_WIN - 1)) begin
        cnt_d = '0;
        state_d = (o_q == 4'(LEN_ONIJ - 1)) ? FIN : ACC;
        o_d = o_q + 4'd1;
      end
      FIN: begin
        cnt_d = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // outputs are decoded from the next phase so the registered copies line up with the state
  always_comb begin
    inst_d = IDLE_INST;
    inst_d[B_IFIFO_WR] = 1'b0;
    inst_d[B_IFIFO_RD] = 1'b0;
    case (state_d)
      L0W_W: begin
        if (cnt_d < 6'(COL)) begin
          inst_d[B_CEN_X] = 1'b0;
          inst_d[B_WEN_X] = 1'b1;
          inst_d[B_A_X +: 11] = WBASE + 11'(kij_d) * 11'(COL) + 11'(cnt_d);
        end
        inst_d[B_L0_WR] = cnt_d != '0;
      end
      KLOAD: begin
        inst_d[B_L0_RD] = 1'b1;
        inst_d[B_LOAD] = 1'b1;
      end
      L0W_X: begin
        if (cnt_d < 6'(LEN_NIJ)) begin
          inst_d[B_CEN_X] = 1'b0;
          inst_d[B_A_X +: 11] = 11'(cnt_d);
        end
        inst_d[B_L0_WR] = cnt_d != '0;
      end
      EXEC: begin
        inst_d[B_EXEC] = cnt_d < 6'(LEN_NIJ);
        inst_d[B_L0_RD] = cnt_d < 6'(LEN_NIJ);
      end
      DRAIN: begin
        inst_d[B_OFIFO_RD] = cnt_d < 6'(LEN_NIJ);
        if (cnt_d != '0) begin
          inst_d[B_CEN_P] = 1'b0;
          inst_d[B_WEN_P] = 1'b0;
          inst_d[B_A_P +: 11] = 11'(kij_d) * 11'(LEN_NIJ) + 11'(cnt_d) - 11'd1;
        end
      end
      ACC: begin
        if (cnt_d >= 6'd1 && cnt_d <= 6'd9) begin
          inst_d[B_CEN_P] = 1'b0;
          inst_d[B_A_P +: 11] = acc_addr;
        end
        inst_d[B_ACC] = cnt_d >= 6'd2 && cnt_d <= 6'd10;
      end
      default: ;
    endcase
    sfp_clr_d = state_d == ACC && cnt_d == '0;
    out_valid_d = state_d == ACC && cnt_d == 6'(ACC_WIN - 1);
    out_idx_d = out_valid_d ? o_d : '0;
    busy_d = state_d != IDLE && state_d != FIN;
    done_d = state_d == FIN;
  end

  // state, counters and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      kij_q <= '0;
      o_q <= '0;
      inst_q <= IDLE_INST;
      sfp_clr_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_idx_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      kij_q <= kij_d;
      o_q <= o_d;
      inst_q <= inst_d;
      sfp_clr_q <= sfp_clr_d;
      out_valid_q <= out_valid_d;
      out_idx_q <= out_idx_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign inst = inst_q;
  assign sfp_clr = sfp_clr_q;
  assign out_valid = out_valid_q;
  assign out_idx = out_idx_q;
  assign busy = busy_q;
  assign done = done_q;

`ifdef CORE_CTRL_PERF_EN
  logic [31:0] perf_cycles_q, perf_cycles_d;
  logic [15:0] perf_stall_q, perf_stall_d;

  // run-level busy and stall counters, restarted by an accepted start and held after done
  always_comb begin
    perf_cycles_d = perf_cycles_q + 32'(busy_q);
    perf_stall_d = perf_stall_q + 16'(state_q == WAIT_OF);
    if (state_q == IDLE && start) begin
      perf_cycles_d = '0;
      perf_stall_d = '0;
    end
  end

  // perf counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_cycles_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_cycles_q <= perf_cycles_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_stall = perf_stall_q;
`endif
endmodule
